if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 129 ++++++++++++
 tb/tb_if_stage.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, a FETCH/HOLD handshake
// with instruction memory, and the IF/ID pipeline register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_plus4,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic        redirect;
    logic [31:0] next_pc;

    assign pc_plus4 = pc_q + 32'd4;
    assign redirect = jump | branch_taken;
    assign next_pc  = jump ? jump_target : (branch_taken ? branch_target : pc_plus4);

    // Request is gated by rst_n so it drops immediately while reset is held.
    assign imem_req  = rst_n && (state_q == FETCH);
    assign imem_addr = pc_q;

    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;

        if (redirect) begin
            // Any ack or buffered word belongs to the abandoned path.
            pc_d    = next_pc;
            state_d = FETCH;
            hold_d  = NOP;
            if (!stall) begin
                instr_d = NOP;
                pc4_d   = 32'h0;
                valid_d = 1'b0;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ack) begin
                        if (!stall) begin
                            instr_d = imem_rdata;
                            pc4_d   = pc_plus4;
                            valid_d = 1'b1;
                            pc_d    = next_pc;
                        end else begin
                            hold_d  = imem_rdata;
                            state_d = HOLD;
                        end
                    end else if (!stall) begin
                        instr_d = NOP;
                        pc4_d   = 32'h0;
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_d = hold_q;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end

        // Flush only touches IF/ID; PC and FSM proceed as computed above.
        if (flush) begin
            instr_d = NOP;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            hold_q  <= 32'h0;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory returns the address as the instruction word
// while acking, and a marker word otherwise.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_plus4;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    int n_asrt = 0;
    int n_fail = 0;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .pc_plus4     (pc_plus4),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid)
    );

    assign imem_rdata = imem_ack ? imem_addr : 32'hDEAD_BEEF;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] p4,
                            input logic v);
        chk({tag, "_instr"}, if_id_instr, ins);
        chk({tag, "_pc4"}, if_id_pc4, p4);
        chk({tag, "_valid"}, {31'h0, if_id_valid}, {31'h0, v});
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
        chk({tag, "_req"}, {31'h0, imem_req}, {31'h0, r});
        chk({tag, "_addr"}, imem_addr, a);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0;
        jump = 1'b0; jump_target = 32'h0; imem_ack = 1'b0;

        #3;
        chk_req("rst", 1'b0, 32'h0);
        chk_ifid("rst", 32'h0, 32'h0, 1'b0);
        chk("rst_pc4", pc_plus4, 32'h4);

        // Release reset; first edge must see a request at RESET_PC.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_req("rel", 1'b1, 32'h0);

        // Zero-wait streaming
        imem_ack = 1'b1;
        tick(); chk_ifid("s0", 32'h0, 32'h4, 1'b1);
        tick(); chk_ifid("s1", 32'h4, 32'h8, 1'b1);
        tick(); chk_ifid("s2", 32'h8, 32'hC, 1'b1);
        tick(); chk_ifid("s3", 32'hC, 32'h10, 1'b1);
        chk_req("s3", 1'b1, 32'h10);

        // Stall during ack at 0x10: three stalled cycles, ack only on the first
        stall = 1'b1;
        tick(); chk_req("h0", 1'b0, 32'h10); chk_ifid("h0", 32'hC, 32'h10, 1'b1);
        imem_ack = 1'b0;
        tick(); chk_req("h1", 1'b0, 32'h10); chk_ifid("h1", 32'hC, 32'h10, 1'b1);
        tick(); chk_req("h2", 1'b0, 32'h10);
        stall = 1'b0;
        tick(); chk_ifid("hrel", 32'h10, 32'h14, 1'b1); chk_req("hrel", 1'b1, 32'h14);

        // Simultaneous jump and branch under stall: jump wins, IF/ID held
        jump = 1'b1; jump_target = 32'h400;
        branch_taken = 1'b1; branch_target = 32'h200;
        stall = 1'b1;
        tick(); chk_req("jb", 1'b1, 32'h400); chk_ifid("jb", 32'h10, 32'h14, 1'b1);
        jump = 1'b0; branch_taken = 1'b0; stall = 1'b0;
        tick(); chk_ifid("wait", 32'h0, 32'h0, 1'b0); chk_req("wait", 1'b1, 32'h400);

        // Wait states at 0x20, then branch to 0x80 arriving with the ack
        jump = 1'b1; jump_target = 32'h20;
        tick(); chk_req("j20", 1'b1, 32'h20); chk_ifid("j20", 32'h0, 32'h0, 1'b0);
        jump = 1'b0;
        tick(); chk_req("ws1", 1'b1, 32'h20);
        branch_taken = 1'b1; branch_target = 32'h80; imem_ack = 1'b1;
        tick(); chk_req("br", 1'b1, 32'h80); chk_ifid("br", 32'h0, 32'h0, 1'b0);
        branch_taken = 1'b0;
        tick(); chk_ifid("a80", 32'h80, 32'h84, 1'b1); chk_req("a80", 1'b1, 32'h84);

        // Flush with stall while valid: bubble, FSM still enters HOLD at 0x84
        flush = 1'b1; stall = 1'b1;
        tick(); chk_ifid("fl", 32'h0, 32'h0, 1'b0); chk_req("fl", 1'b0, 32'h84);
        flush = 1'b0; stall = 1'b0; imem_ack = 1'b0;
        tick(); chk_ifid("flrel", 32'h84, 32'h88, 1'b1); chk_req("flrel", 1'b1, 32'h88);

        // PC wrap at 0xFFFF_FFFC
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        tick(); chk_req("jw", 1'b1, 32'hFFFF_FFFC); chk("wrap_pc4", pc_plus4, 32'h0);
        jump = 1'b0; imem_ack = 1'b1;
        tick(); chk_ifid("wrap", 32'hFFFF_FFFC, 32'h0, 1'b1); chk_req("wrap", 1'b1, 32'h0);
        tick(); chk_ifid("w0", 32'h0, 32'h4, 1'b1); chk_req("w0", 1'b1, 32'h4);

        // Enter HOLD at 0x4, then assert reset between edges
        stall = 1'b1;
        tick(); chk_req("wh", 1'b0, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk_req("arst", 1'b0, 32'h0);
        chk_ifid("arst", 32'h0, 32'h0, 1'b0);
        stall = 1'b0;
        tick(); chk_req("arst2", 1'b0, 32'h0); chk_ifid("arst2", 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
        #1;
        chk_req("rel2", 1'b1, 32'h0);
        tick(); chk_ifid("late", 32'h0, 32'h4, 1'b1); chk_req("late", 1'b1, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
